// File: rtl/key_fifo_irq.sv
// Keyboard FIFO: buffers decoder keycodes, exposes DATA/STATUS on the CPU bus,
// and raises a level interrupt vector while data is pending until acknowledged.
module key_fifo_irq #(
    parameter int          DEPTH    = 16,
    parameter logic [63:0] KEY_BASE = 64'h8000_0010,
    parameter logic [3:0]  VECTOR   = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_data,
    input  logic [63:0] bus_address,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    input  logic [63:0] bus_write_data,
    output logic [63:0] bus_read_data,
    output logic [3:0]  interrupt_vector,
    input  logic        interrupt_ack
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ASSERT, WAIT} irq_state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow, rd_hit_q;
    irq_state_t    state;

    logic rd_hit, st_hit, st_wr, full, empty, rd_edge, pop, key_ok, push, drop;
    logic [7:0] cnt8;
    logic unused_wdata;

    assign rd_hit  = bus_read_enable && (bus_address == KEY_BASE);
    assign st_hit  = bus_read_enable && (bus_address == KEY_BASE + 64'd8);
    assign st_wr   = bus_write_enable && (bus_address == KEY_BASE + 64'd8);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Only the first cycle of a held read pops, so a slow CPU read consumes one byte.
    assign rd_edge = rd_hit && !rd_hit_q;
    assign pop     = rd_edge && !empty;
    assign key_ok  = key_valid && (key_data != 8'd0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push    = key_ok && (!full || pop);
    assign drop    = key_ok && full && !pop;
    assign cnt8    = 8'(count);
    assign unused_wdata = ^{bus_write_data[63:2], bus_write_data[0]};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= key_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            overflow         <= 1'b0;
            rd_hit_q         <= 1'b0;
            bus_read_data    <= '0;
            interrupt_vector <= '0;
            state            <= IDLE;
        end else begin
            rd_hit_q <= rd_hit;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (drop)
                overflow <= 1'b1;
            else if (st_wr && bus_write_data[1])
                overflow <= 1'b0;

            if (rd_hit) begin
                if (rd_edge)
                    bus_read_data <= empty ? 64'd0 : {56'd0, mem[rd_ptr]};
            end else if (st_hit) begin
                bus_read_data <= {48'd0, cnt8, 6'd0, overflow, ~empty};
            end

            case (state)
                IDLE: if (!empty) begin
                    state            <= ASSERT;
                    interrupt_vector <= VECTOR;
                end
                ASSERT: if (interrupt_ack) begin
                    state            <= WAIT;
                    interrupt_vector <= '0;
                end
                WAIT: if (pop) state <= IDLE;
                default: begin
                    state            <= IDLE;
                    interrupt_vector <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_fifo_irq.sv
// Directed bench for key_fifo_irq: a vector table for basic flow plus
// hand sequences for overflow, full push+pop and mid-operation reset.
module tb_key_fifo_irq;
    localparam logic [63:0] KB = 64'h8000_0010;
    localparam logic [1:0] OP_NONE = 2'd0, OP_DATA = 2'd1, OP_STAT = 2'd2, OP_WSTAT = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_data = 8'd0;
    logic [63:0] bus_address = '0;
    logic        bus_read_enable = 1'b0;
    logic        bus_write_enable = 1'b0;
    logic [63:0] bus_write_data = '0;
    logic [63:0] bus_read_data;
    logic [3:0]  interrupt_vector;
    logic        interrupt_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    key_fifo_irq dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_data(key_data),
        .bus_address(bus_address), .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable), .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data), .interrupt_vector(interrupt_vector),
        .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        kv;
        logic [7:0]  kd;
        logic [1:0]  op;
        logic        ack;
        int          reps;
        logic [63:0] exp_rd;
        logic [3:0]  exp_vec;
    } vec_t;

    vec_t tbl[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_bus(input logic [1:0] op, input logic [63:0] wd);
        bus_read_enable  = (op == OP_DATA) || (op == OP_STAT);
        bus_write_enable = (op == OP_WSTAT);
        bus_address      = (op == OP_DATA) ? KB : (op == OP_NONE) ? 64'd0 : KB + 64'd8;
        bus_write_data   = wd;
    endtask

    task automatic bus_op(input logic [1:0] op, input logic [63:0] exp, input string nm);
        set_bus(op, 64'd0);
        cyc();
        chk(nm, bus_read_data, exp);
        set_bus(OP_NONE, 64'd0);
        cyc();
    endtask

    task automatic push_key(input logic [7:0] k);
        key_valid = 1'b1;
        key_data  = k;
        cyc();
        key_valid = 1'b0;
        key_data  = 8'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key_valid = 1'b0;
        interrupt_ack = 1'b0;
        set_bus(OP_NONE, 64'd0);
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        // reset state, single key, ordering
        tbl.push_back('{1'b0, 8'h00, OP_STAT, 1'b0, 1,  64'h0,   4'd0});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b0, 1,  64'h0,   4'd0});
        tbl.push_back('{1'b0, 8'h00, OP_DATA, 1'b0, 1,  64'h0,   4'd0});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b0, 1,  64'h0,   4'd0});
        tbl.push_back('{1'b1, 8'h41, OP_NONE, 1'b0, 1,  64'h0,   4'd0});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b0, 1,  64'h0,   4'd1});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b1, 1,  64'h0,   4'd0});
        tbl.push_back('{1'b0, 8'h00, OP_STAT, 1'b0, 1,  64'h101, 4'd0});
        tbl.push_back('{1'b0, 8'h00, OP_DATA, 1'b0, 20, 64'h41,  4'd0});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b0, 1,  64'h41,  4'd0});
        tbl.push_back('{1'b0, 8'h00, OP_STAT, 1'b0, 1,  64'h0,   4'd0});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b0, 3,  64'h0,   4'd0});
        tbl.push_back('{1'b1, 8'h61, OP_NONE, 1'b0, 1,  64'h0,   4'd0});
        tbl.push_back('{1'b1, 8'h62, OP_NONE, 1'b0, 1,  64'h0,   4'd1});
        tbl.push_back('{1'b1, 8'h63, OP_NONE, 1'b0, 1,  64'h0,   4'd1});
        tbl.push_back('{1'b0, 8'h00, OP_DATA, 1'b0, 1,  64'h61,  4'd1});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b0, 1,  64'h61,  4'd1});
        tbl.push_back('{1'b0, 8'h00, OP_DATA, 1'b0, 1,  64'h62,  4'd1});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b0, 1,  64'h62,  4'd1});
        tbl.push_back('{1'b0, 8'h00, OP_DATA, 1'b0, 1,  64'h63,  4'd1});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b0, 1,  64'h63,  4'd1});
        tbl.push_back('{1'b0, 8'h00, OP_DATA, 1'b0, 1,  64'h0,   4'd1});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b0, 1,  64'h0,   4'd1});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b1, 1,  64'h0,   4'd0});
        tbl.push_back('{1'b0, 8'h00, OP_NONE, 1'b0, 2,  64'h0,   4'd0});

        do_reset();
        chk("reset_vec", {60'd0, interrupt_vector}, 64'd0);
        chk("reset_rd", bus_read_data, 64'd0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                key_valid     = tbl[i].kv;
                key_data      = tbl[i].kd;
                interrupt_ack = tbl[i].ack;
                set_bus(tbl[i].op, 64'd0);
                cyc();
                chk($sformatf("tbl%0d_rd", i), bus_read_data, tbl[i].exp_rd);
                chk($sformatf("tbl%0d_vec", i), {60'd0, interrupt_vector}, {60'd0, tbl[i].exp_vec});
            end
        end
        key_valid = 1'b0;
        interrupt_ack = 1'b0;
        set_bus(OP_NONE, 64'd0);
        cyc();

        // overflow: 17 keys into 16 entries
        do_reset();
        key_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            key_data = 8'h30 + 8'(i);
            cyc();
        end
        key_valid = 1'b0;
        key_data  = 8'd0;
        chk("ovf_vec", {60'd0, interrupt_vector}, 64'd1);
        bus_op(OP_STAT, 64'h1003, "ovf_status");
        bus_op(OP_DATA, 64'h30,   "ovf_first");
        bus_op(OP_STAT, 64'h0F03, "ovf_status2");
        set_bus(OP_WSTAT, 64'h2);
        cyc();
        set_bus(OP_NONE, 64'd0);
        cyc();
        bus_op(OP_STAT, 64'h0F01, "ovf_cleared");

        // full FIFO with push and pop in the same cycle
        push_key(8'h41);
        bus_op(OP_STAT, 64'h1001, "full_status");
        key_valid = 1'b1;
        key_data  = 8'h42;
        set_bus(OP_DATA, 64'd0);
        cyc();
        chk("pushpop_rd", bus_read_data, 64'h31);
        key_valid = 1'b0;
        key_data  = 8'd0;
        set_bus(OP_NONE, 64'd0);
        cyc();
        bus_op(OP_STAT, 64'h1001, "pushpop_status");
        for (int j = 0; j < 16; j++) begin
            logic [63:0] e;
            e = (j < 14) ? 64'(8'h32 + 8'(j)) : (j == 14) ? 64'h41 : 64'h42;
            bus_op(OP_DATA, e, $sformatf("drain%0d", j));
        end
        bus_op(OP_STAT, 64'h0, "drained_status");

        // zero keycodes, then reset during ASSERT with a held read
        do_reset();
        key_valid = 1'b1;
        key_data  = 8'h00;
        cyc();
        cyc();
        key_valid = 1'b0;
        bus_op(OP_STAT, 64'h0, "zero_key_status");
        chk("zero_key_vec", {60'd0, interrupt_vector}, 64'd0);
        push_key(8'h11);
        push_key(8'h22);
        push_key(8'h33);
        chk("q3_vec", {60'd0, interrupt_vector}, 64'd1);
        bus_op(OP_STAT, 64'h0301, "q3_status");
        set_bus(OP_DATA, 64'd0);
        cyc();
        chk("held_rd", bus_read_data, 64'h11);
        reset = 1'b1;
        #1;
        chk("midrst_vec", {60'd0, interrupt_vector}, 64'd0);
        chk("midrst_rd", bus_read_data, 64'd0);
        set_bus(OP_NONE, 64'd0);
        cyc();
        reset = 1'b0;
        bus_op(OP_STAT, 64'h0, "post_rst_status");
        chk("post_rst_vec", {60'd0, interrupt_vector}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
